hazard_unit_mc: RTL and testbench
=================================

// Module: hazard_unit_mc
// PURPOSE
//  Parametrised hazard/forwarding unit for the 5-stage RV32I pipeline, adding multi-cycle EX ops (mul/div) and data-memory wait states.
//  Produces per-stage stall/flush controls and forwarding selects, plus saturating stall/flush performance counters.
//  Sits beside the controller; consumes decoded stage fields, drives datapath and controller.
// PARAMETERS
//  REG_AW      5    register-address width
//  FWD_EN      1    1: M/W forwarding + load-use stall; 0: no forwarding, RAW stall vs E and M writers
//  MC_TMO      64   max cycles in MC_BUSY before watchdog abort (>=2)
//  PERF_W      32   width of performance counters
// PORTS
//  clk                  in   1       clock, rising edge
//  reset                in   1       asynchronous, active-high reset
//  Di_rs1, Di_rs2       in   REG_AW  source regs of instr in D
//  Ei_rs1, Ei_rs2       in   REG_AW  source regs of instr in E
//  Ei_rd, Mi_rd, Wi_rd  in   REG_AW  dest regs in E/M/W
//  Ei_regWrite, Mi_regWrite, Wi_regWrite  in 1 stage writes rd
//  Ei_resultSrc, Mi_resultSrc  in 2  00 ALU, 01 load, 10 immPlus, 11 PC+4
//  Ei_PCSrc             in   2       !=00 -> taken branch/jal/jalr redirect
//  Ei_mcOp              in   1       instr in E is multi-cycle
//  Ei_mcDone            in   1       multi-cycle unit result valid this cycle
//  Mi_memOp, Mi_memReady in  1       M is load/store; data memory ready
//  Eo_forwardIn1Src, Eo_forwardIn2Src  out 2  00 RD, 01 W result, 10 M immPlus, 11 M ALUOut
//  Fo_stall, Do_stall, Eo_stall, Mo_stall  out 1  hold pipeline reg feeding that stage
//  Do_flush, Eo_flush, Mo_flush, Wo_flush  out 1  load bubble into that reg at next edge
//  Eo_mcStart           out  1       one-cycle start pulse to multi-cycle unit
//  o_mcTimeout          out  1       sticky watchdog flag, cleared only by reset
//  o_stallCnt, o_flushCnt  out PERF_W  saturating counts of cycles with Fo_stall / Do_flush
// BEHAVIOUR
//  Reset: all outputs 0, FSM MC_IDLE, counters 0, watchdog count 0; reset asserted mid-op drops all stalls immediately.
//  Forwarding (FWD_EN=1), per rs in E; rs==0 -> 00; M match with Mi_regWrite: resultSrc 00->11, 10->10, else 00; otherwise W match with Wi_regWrite -> 01; M wins over W. FWD_EN=0 -> always 00.
//  Hazard terms (rd/rs==0 never matches):
//   memWait = Mi_memOp & !Mi_memReady
//   mcBusy  = state==MC_BUSY & !Ei_mcDone
//   redirect= Ei_PCSrc!=00
//   ldUse   = FWD_EN & Ei_resultSrc==01 & Ei_regWrite & Di_rs{1,2}==Ei_rd
//   raw     = !FWD_EN & Di_rs{1,2} matches (Ei_rd&Ei_regWrite | Mi_rd&Mi_regWrite)
//  Priority, highest first:
//   memWait : F,D,E,M stall; Wo_flush; all other flush 0
//   mcBusy  : F,D,E stall; Mo_flush
//   redirect: Do_flush, Eo_flush; no stall (redirect overrides ldUse/raw)
//   ldUse|raw: F,D stall; Eo_flush
//  MC FSM (states MC_IDLE, MC_BUSY):
//   IDLE->BUSY when Ei_mcOp & !memWait; Eo_mcStart=1 that cycle; E,F,D stall, Mo_flush
//   BUSY: wdog increments each cycle; Ei_mcDone -> IDLE, stalls release that cycle (result advances to M)
//   BUSY & wdog==MC_TMO-1 & !Ei_mcDone -> IDLE, set o_mcTimeout, Eo_flush|Mo_flush (op dropped)
//   memWait during BUSY: FSM holds, wdog frozen; done pulse while memWait is not lost (FSM stays BUSY until memWait clears and done seen again; the multi-cycle unit holds done high)
//  Counters: +1 per qualifying cycle, saturate at all-ones, no wrap.
//  All stall/flush/forward outputs combinational from inputs + state; only FSM, wdog, counters, and flag are registered.
// STRUCTURE
//  hazard_pkg: resultSrc, PCSrc, and forward-select localparams; MC state encoding; hazard priority enum.
//  Sub-module hazard_mc_fsm: FSM + watchdog (ports: clk, reset, Ei_mcOp, Ei_mcDone, memWait -> state, Eo_mcStart, timeout).
//  Top: forwarding mux select, hazard-term decode, priority resolve, perf counters.
// TESTING
//  ALU x5 in M, E rs1=x5 -> Eo_forwardIn1Src=11; same x5 also in W -> still 11; rs1=x0 -> 00.
//  lw x6 in E, D rs2=x6 -> Fo/Do_stall=1, Eo_flush=1 for one cycle; with Ei_PCSrc=01 -> Do_flush/Eo_flush=1, no stall.
//  FWD_EN=0: add x7 in M, D rs1=x7 -> Fo_stall=1, Eo_flush=1; fwd selects stay 00.
//  mul in E, done after 5 cycles -> Eo_mcStart 1 pulse, F/D/E stalled + Mo_flush for 5 cycles, release on done, o_stallCnt=5.
//  MC_TMO=8, done never -> abort at cycle 8, o_mcTimeout=1 sticky; reset asserted at cycle 4 -> all outputs 0 asynchronously.
//  Mi_memReady low 3 cycles during mul BUSY -> F..M stalled, Wo_flush=1, wdog frozen; counter preloaded all-ones stays all-ones.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared encodings for the multi-cycle hazard unit: result sources, redirect,
// forwarding selects, multi-cycle FSM states and hazard priority classes.
package hazard_pkg;
  localparam logic [1:0] RES_ALU  = 2'b00;
  localparam logic [1:0] RES_LOAD = 2'b01;
  localparam logic [1:0] RES_IMM  = 2'b10;
  localparam logic [1:0] RES_PC4  = 2'b11;

  localparam logic [1:0] PC_SEQ = 2'b00;

  localparam logic [1:0] FWD_RD    = 2'b00;
  localparam logic [1:0] FWD_W     = 2'b01;
  localparam logic [1:0] FWD_M_IMM = 2'b10;
  localparam logic [1:0] FWD_M_ALU = 2'b11;

  typedef enum logic {
    MC_IDLE = 1'b0,
    MC_BUSY = 1'b1
  } mc_state_t;

  typedef enum logic [2:0] {
    HZ_NONE,
    HZ_LDRAW,
    HZ_REDIRECT,
    HZ_MC,
    HZ_MEMWAIT
  } hz_prio_t;
endpackage

// File: rtl/hazard_mc_fsm.sv
// Multi-cycle EX op sequencer: issues the start pulse, tracks BUSY and
// aborts the op through a watchdog that freezes while data memory waits.
module hazard_mc_fsm
  import hazard_pkg::*;
#(
  parameter int MC_TMO = 64
) (
  input  logic      clk,
  input  logic      reset,
  input  logic      Ei_mcOp,
  input  logic      Ei_mcDone,
  input  logic      memWait,
  output mc_state_t state,
  output logic      Eo_mcStart,
  output logic      timeout
);
  localparam int WD_W = $clog2(MC_TMO);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(MC_TMO - 1);

  mc_state_t       state_nxt;
  logic [WD_W-1:0] wdog, wdog_nxt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= MC_IDLE;
      wdog  <= '0;
    end else begin
      state <= state_nxt;
      wdog  <= wdog_nxt;
    end
  end

  // A done seen while memory waits is ignored; the unit keeps done high until accepted.
  always_comb begin
    state_nxt  = state;
    wdog_nxt   = wdog;
    Eo_mcStart = 1'b0;
    timeout    = 1'b0;
    case (state)
      MC_IDLE: begin
        if (Ei_mcOp && !memWait) begin
          Eo_mcStart = 1'b1;
          state_nxt  = MC_BUSY;
          wdog_nxt   = '0;
        end
      end
      MC_BUSY: begin
        if (!memWait) begin
          if (Ei_mcDone) begin
            state_nxt = MC_IDLE;
          end else if (wdog == WD_LAST) begin
            timeout   = 1'b1;
            state_nxt = MC_IDLE;
          end else begin
            wdog_nxt = wdog + 1'b1;
          end
        end
      end
      default: state_nxt = MC_IDLE;
    endcase
  end
endmodule

// File: rtl/hazard_unit_mc.sv
// Hazard/forwarding unit for the 5-stage RV32I pipeline with multi-cycle EX ops,
// data-memory wait states and saturating stall/flush performance counters.
module hazard_unit_mc
  import hazard_pkg::*;
#(
  parameter int REG_AW = 5,
  parameter int FWD_EN = 1,
  parameter int MC_TMO = 64,
  parameter int PERF_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [REG_AW-1:0] Di_rs1,
  input  logic [REG_AW-1:0] Di_rs2,
  input  logic [REG_AW-1:0] Ei_rs1,
  input  logic [REG_AW-1:0] Ei_rs2,
  input  logic [REG_AW-1:0] Ei_rd,
  input  logic [REG_AW-1:0] Mi_rd,
  input  logic [REG_AW-1:0] Wi_rd,
  input  logic              Ei_regWrite,
  input  logic              Mi_regWrite,
  input  logic              Wi_regWrite,
  input  logic [1:0]        Ei_resultSrc,
  input  logic [1:0]        Mi_resultSrc,
  input  logic [1:0]        Ei_PCSrc,
  input  logic              Ei_mcOp,
  input  logic              Ei_mcDone,
  input  logic              Mi_memOp,
  input  logic              Mi_memReady,
  output logic [1:0]        Eo_forwardIn1Src,
  output logic [1:0]        Eo_forwardIn2Src,
  output logic              Fo_stall,
  output logic              Do_stall,
  output logic              Eo_stall,
  output logic              Mo_stall,
  output logic              Do_flush,
  output logic              Eo_flush,
  output logic              Mo_flush,
  output logic              Wo_flush,
  output logic              Eo_mcStart,
  output logic              o_mcTimeout,
  output logic [PERF_W-1:0] o_stallCnt,
  output logic [PERF_W-1:0] o_flushCnt
);
  localparam bit FWD_ON = (FWD_EN != 0);

  function automatic logic hit(input logic [REG_AW-1:0] rs, input logic [REG_AW-1:0] rd);
    hit = (rd != '0) && (rs == rd);
  endfunction

  function automatic logic [1:0] fwd_sel(input logic [REG_AW-1:0] rs,
                                         input logic [REG_AW-1:0] m_rd, input logic m_we,
                                         input logic [1:0] m_src,
                                         input logic [REG_AW-1:0] w_rd, input logic w_we);
    fwd_sel = FWD_RD;
    if (m_we && hit(rs, m_rd)) begin
      case (m_src)
        RES_ALU:           fwd_sel = FWD_M_ALU;
        RES_IMM:           fwd_sel = FWD_M_IMM;
        RES_LOAD, RES_PC4: fwd_sel = FWD_RD;
        default:           fwd_sel = FWD_RD;
      endcase
    end else if (w_we && hit(rs, w_rd)) begin
      fwd_sel = FWD_W;
    end
  endfunction

  function automatic logic [PERF_W-1:0] sat_inc(input logic [PERF_W-1:0] c, input logic en);
    sat_inc = (en && (c != '1)) ? c + 1'b1 : c;
  endfunction

  mc_state_t mc_state;
  logic      mc_start, mc_abort;
  logic      mem_wait, mc_busy, redirect, e_hit, m_hit, ld_use, raw;
  hz_prio_t  prio;

  assign mem_wait = Mi_memOp & ~Mi_memReady;

  hazard_mc_fsm #(.MC_TMO(MC_TMO)) u_mc_fsm (
    .clk        (clk),
    .reset      (reset),
    .Ei_mcOp    (Ei_mcOp),
    .Ei_mcDone  (Ei_mcDone),
    .memWait    (mem_wait),
    .state      (mc_state),
    .Eo_mcStart (mc_start),
    .timeout    (mc_abort)
  );

  assign mc_busy  = (mc_state == MC_BUSY) & ~Ei_mcDone;
  assign redirect = (Ei_PCSrc != PC_SEQ);
  assign e_hit    = Ei_regWrite & (hit(Di_rs1, Ei_rd) | hit(Di_rs2, Ei_rd));
  assign m_hit    = Mi_regWrite & (hit(Di_rs1, Mi_rd) | hit(Di_rs2, Mi_rd));
  assign ld_use   = FWD_ON & (Ei_resultSrc == RES_LOAD) & e_hit;
  assign raw      = ~FWD_ON & (e_hit | m_hit);

  always_comb begin
    prio = HZ_NONE;
    if (mem_wait)                  prio = HZ_MEMWAIT;
    else if (mc_busy || mc_start)  prio = HZ_MC;
    else if (redirect)             prio = HZ_REDIRECT;
    else if (ld_use || raw)        prio = HZ_LDRAW;
  end

  // Reset forces every control low at once, even mid-operation; on abort the E flush wins over its stall.
  always_comb begin
    Fo_stall = 1'b0; Do_stall = 1'b0; Eo_stall = 1'b0; Mo_stall = 1'b0;
    Do_flush = 1'b0; Eo_flush = 1'b0; Mo_flush = 1'b0; Wo_flush = 1'b0;
    Eo_mcStart       = 1'b0;
    Eo_forwardIn1Src = FWD_RD;
    Eo_forwardIn2Src = FWD_RD;
    if (!reset) begin
      Eo_mcStart = mc_start;
      if (FWD_ON) begin
        Eo_forwardIn1Src = fwd_sel(Ei_rs1, Mi_rd, Mi_regWrite, Mi_resultSrc, Wi_rd, Wi_regWrite);
        Eo_forwardIn2Src = fwd_sel(Ei_rs2, Mi_rd, Mi_regWrite, Mi_resultSrc, Wi_rd, Wi_regWrite);
      end
      case (prio)
        HZ_MEMWAIT: begin
          Fo_stall = 1'b1; Do_stall = 1'b1; Eo_stall = 1'b1; Mo_stall = 1'b1;
          Wo_flush = 1'b1;
        end
        HZ_MC: begin
          Fo_stall = 1'b1; Do_stall = 1'b1; Eo_stall = 1'b1;
          Mo_flush = 1'b1;
          Eo_flush = mc_abort;
        end
        HZ_REDIRECT: begin
          Do_flush = 1'b1; Eo_flush = 1'b1;
        end
        HZ_LDRAW: begin
          Fo_stall = 1'b1; Do_stall = 1'b1;
          Eo_flush = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      o_stallCnt  <= '0;
      o_flushCnt  <= '0;
      o_mcTimeout <= 1'b0;
    end else begin
      o_stallCnt  <= sat_inc(o_stallCnt, Fo_stall);
      o_flushCnt  <= sat_inc(o_flushCnt, Do_flush);
      o_mcTimeout <= o_mcTimeout | mc_abort;
    end
  end
endmodule

// File: tb/tb_hazard_unit_mc.sv
// Directed bench for hazard_unit_mc: forwarding-enabled instance (MC_TMO=8,
// 4-bit counters) plus a forwarding-disabled instance sharing the same inputs.
module tb_hazard_unit_mc;
  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] Di_rs1, Di_rs2, Ei_rs1, Ei_rs2, Ei_rd, Mi_rd, Wi_rd;
  logic       Ei_regWrite, Mi_regWrite, Wi_regWrite;
  logic [1:0] Ei_resultSrc, Mi_resultSrc, Ei_PCSrc;
  logic       Ei_mcOp, Ei_mcDone, Mi_memOp, Mi_memReady;

  logic [1:0] a_f1, a_f2, n_f1, n_f2;
  logic       a_fs, a_ds, a_es, a_ms, a_df, a_ef, a_mf, a_wf, a_st, a_to;
  logic       n_fs, n_ds, n_es, n_ms, n_df, n_ef, n_mf, n_wf, n_st, n_to;
  logic [3:0] a_sc, a_fc, n_sc, n_fc;
  logic [8:0] a_ctl, n_ctl;

  int n_chk = 0;
  int n_err = 0;

  // Control vector order: F D E M stall | D E M W flush | mcStart
  assign a_ctl = {a_fs, a_ds, a_es, a_ms, a_df, a_ef, a_mf, a_wf, a_st};
  assign n_ctl = {n_fs, n_ds, n_es, n_ms, n_df, n_ef, n_mf, n_wf, n_st};

  always #5 clk = ~clk;

  hazard_unit_mc #(.REG_AW(5), .FWD_EN(1), .MC_TMO(8), .PERF_W(4)) dut (
    .clk(clk), .reset(reset),
    .Di_rs1(Di_rs1), .Di_rs2(Di_rs2), .Ei_rs1(Ei_rs1), .Ei_rs2(Ei_rs2),
    .Ei_rd(Ei_rd), .Mi_rd(Mi_rd), .Wi_rd(Wi_rd),
    .Ei_regWrite(Ei_regWrite), .Mi_regWrite(Mi_regWrite), .Wi_regWrite(Wi_regWrite),
    .Ei_resultSrc(Ei_resultSrc), .Mi_resultSrc(Mi_resultSrc), .Ei_PCSrc(Ei_PCSrc),
    .Ei_mcOp(Ei_mcOp), .Ei_mcDone(Ei_mcDone), .Mi_memOp(Mi_memOp), .Mi_memReady(Mi_memReady),
    .Eo_forwardIn1Src(a_f1), .Eo_forwardIn2Src(a_f2),
    .Fo_stall(a_fs), .Do_stall(a_ds), .Eo_stall(a_es), .Mo_stall(a_ms),
    .Do_flush(a_df), .Eo_flush(a_ef), .Mo_flush(a_mf), .Wo_flush(a_wf),
    .Eo_mcStart(a_st), .o_mcTimeout(a_to), .o_stallCnt(a_sc), .o_flushCnt(a_fc)
  );

  hazard_unit_mc #(.REG_AW(5), .FWD_EN(0), .MC_TMO(8), .PERF_W(4)) dut_nf (
    .clk(clk), .reset(reset),
    .Di_rs1(Di_rs1), .Di_rs2(Di_rs2), .Ei_rs1(Ei_rs1), .Ei_rs2(Ei_rs2),
    .Ei_rd(Ei_rd), .Mi_rd(Mi_rd), .Wi_rd(Wi_rd),
    .Ei_regWrite(Ei_regWrite), .Mi_regWrite(Mi_regWrite), .Wi_regWrite(Wi_regWrite),
    .Ei_resultSrc(Ei_resultSrc), .Mi_resultSrc(Mi_resultSrc), .Ei_PCSrc(Ei_PCSrc),
    .Ei_mcOp(Ei_mcOp), .Ei_mcDone(Ei_mcDone), .Mi_memOp(Mi_memOp), .Mi_memReady(Mi_memReady),
    .Eo_forwardIn1Src(n_f1), .Eo_forwardIn2Src(n_f2),
    .Fo_stall(n_fs), .Do_stall(n_ds), .Eo_stall(n_es), .Mo_stall(n_ms),
    .Do_flush(n_df), .Eo_flush(n_ef), .Mo_flush(n_mf), .Wo_flush(n_wf),
    .Eo_mcStart(n_st), .o_mcTimeout(n_to), .o_stallCnt(n_sc), .o_flushCnt(n_fc)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic clear_in();
    Di_rs1 = '0; Di_rs2 = '0; Ei_rs1 = '0; Ei_rs2 = '0;
    Ei_rd = '0; Mi_rd = '0; Wi_rd = '0;
    Ei_regWrite = 1'b0; Mi_regWrite = 1'b0; Wi_regWrite = 1'b0;
    Ei_resultSrc = 2'b00; Mi_resultSrc = 2'b00; Ei_PCSrc = 2'b00;
    Ei_mcOp = 1'b0; Ei_mcDone = 1'b0; Mi_memOp = 1'b0; Mi_memReady = 1'b1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    reset = 1'b1;
    clear_in();
    // Hazard and forward inputs present while reset is held: outputs must stay 0
    Ei_resultSrc = 2'b01; Ei_regWrite = 1'b1; Ei_rd = 5'd6; Di_rs2 = 5'd6;
    Mi_rd = 5'd5; Mi_regWrite = 1'b1; Ei_rs1 = 5'd5; Ei_mcOp = 1'b1;
    #2;
    chk("rst_ctl", 32'(a_ctl), 32'(9'b0000_0000_0));
    chk("rst_fwd1", 32'(a_f1), 32'(2'b00));
    chk("rst_cnt", 32'({a_sc, a_fc}), 32'(8'h00));
    chk("rst_to", 32'(a_to), 32'(1'b0));
    clear_in();
    tick();
    reset = 1'b0;

    // Forwarding
    Mi_rd = 5'd5; Mi_regWrite = 1'b1; Mi_resultSrc = 2'b00; Ei_rs1 = 5'd5; #1;
    chk("fwd_m_alu", 32'(a_f1), 32'(2'b11));
    chk("fwd_rs2_none", 32'(a_f2), 32'(2'b00));
    Wi_rd = 5'd5; Wi_regWrite = 1'b1; #1;
    chk("fwd_m_over_w", 32'(a_f1), 32'(2'b11));
    Ei_rs2 = 5'd5; Mi_resultSrc = 2'b10; #1;
    chk("fwd_m_imm", 32'(a_f2), 32'(2'b10));
    Mi_resultSrc = 2'b01; #1;
    chk("fwd_m_load", 32'(a_f1), 32'(2'b00));
    Mi_regWrite = 1'b0; #1;
    chk("fwd_w", 32'(a_f2), 32'(2'b01));
    chk("fwd_nf", 32'({n_f1, n_f2}), 32'(4'b0000));
    Ei_rs1 = 5'd0; Mi_regWrite = 1'b1; Mi_rd = 5'd0; Wi_rd = 5'd0; #1;
    chk("fwd_x0", 32'(a_f1), 32'(2'b00));

    // Load-use, then redirect overriding it
    clear_in();
    Ei_resultSrc = 2'b01; Ei_regWrite = 1'b1; Ei_rd = 5'd6; Di_rs2 = 5'd6; #1;
    chk("lduse_ctl", 32'(a_ctl), 32'(9'b1100_0100_0));
    tick();
    Ei_PCSrc = 2'b01; #1;
    chk("redirect_ctl", 32'(a_ctl), 32'(9'b0000_1100_0));
    chk("stall_cnt1", 32'(a_sc), 32'd1);
    tick();
    clear_in(); #1;
    chk("flush_cnt1", 32'(a_fc), 32'd1);
    chk("idle_ctl", 32'(a_ctl), 32'(9'b0000_0000_0));
    reset = 1'b1; #1;
    chk("async_cnt_clr", 32'({a_sc, a_fc}), 32'(8'h00));
    reset = 1'b0;

    // No-forwarding instance: RAW against M and E writers
    Mi_rd = 5'd7; Mi_regWrite = 1'b1; Di_rs1 = 5'd7; Ei_rs1 = 5'd7; #1;
    chk("raw_m_nf", 32'(n_ctl), 32'(9'b1100_0100_0));
    chk("raw_m_fwd_sel_nf", 32'(n_f1), 32'(2'b00));
    chk("raw_m_fwd_inst", 32'(a_ctl), 32'(9'b0000_0000_0));
    Mi_rd = 5'd0; Di_rs1 = 5'd0; #1;
    chk("raw_x0_nf", 32'(n_ctl), 32'(9'b0000_0000_0));
    Ei_rd = 5'd3; Ei_regWrite = 1'b1; Di_rs2 = 5'd3; #1;
    chk("raw_e_nf", 32'(n_ctl), 32'(9'b1100_0100_0));
    clear_in();

    // Multi-cycle op finishing on the fifth BUSY cycle
    tick();
    Ei_mcOp = 1'b1; #1;
    chk("mul_start", 32'(a_ctl), 32'(9'b1110_0010_1));
    tick();
    for (int i = 0; i < 4; i++) begin
      chk("mul_busy", 32'(a_ctl), 32'(9'b1110_0010_0));
      tick();
    end
    Ei_mcDone = 1'b1; #1;
    chk("mul_done", 32'(a_ctl), 32'(9'b0000_0000_0));
    chk("mul_stall_cnt", 32'(a_sc), 32'd5);
    tick();
    clear_in(); #1;
    chk("mul_after", 32'(a_ctl), 32'(9'b0000_0000_0));
    chk("mul_stall_cnt_hold", 32'(a_sc), 32'd5);
    chk("mul_flush_cnt", 32'(a_fc), 32'd0);

    // Watchdog abort with done never arriving
    Ei_mcOp = 1'b1; #1;
    chk("tmo_start", 32'(a_ctl), 32'(9'b1110_0010_1));
    tick();
    for (int i = 0; i < 7; i++) begin
      chk("tmo_busy", 32'(a_ctl), 32'(9'b1110_0010_0));
      tick();
    end
    chk("tmo_abort", 32'(a_ctl), 32'(9'b1110_0110_0));
    chk("tmo_flag_pre", 32'(a_to), 32'(1'b0));
    tick();
    Ei_mcOp = 1'b0; #1;
    chk("tmo_flag", 32'(a_to), 32'(1'b1));
    chk("tmo_release", 32'(a_ctl), 32'(9'b0000_0000_0));
    chk("tmo_stall_cnt", 32'(a_sc), 32'd14);
    tick();

    // Memory wait during BUSY freezes the watchdog; counter sits at all-ones
    Ei_mcOp = 1'b1; #1;
    chk("mw_start", 32'(a_ctl), 32'(9'b1110_0010_1));
    tick();
    chk("mw_busy1", 32'(a_ctl), 32'(9'b1110_0010_0));
    tick();
    Mi_memOp = 1'b1; Mi_memReady = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("mw_wait", 32'(a_ctl), 32'(9'b1111_0001_0));
      chk("mw_sat", 32'(a_sc), 32'd15);
      tick();
    end
    Mi_memOp = 1'b0; Mi_memReady = 1'b1; #1;
    for (int i = 0; i < 6; i++) begin
      chk("mw_busy_frozen", 32'(a_ctl), 32'(9'b1110_0010_0));
      tick();
    end
    chk("mw_abort", 32'(a_ctl), 32'(9'b1110_0110_0));
    tick();
    Ei_mcOp = 1'b0; #1;
    chk("mw_sat_after", 32'(a_sc), 32'd15);
    chk("mw_flag_sticky", 32'(a_to), 32'(1'b1));
    tick();

    // Reset asserted mid-op on BUSY cycle 4
    Ei_mcOp = 1'b1;
    tick();
    for (int i = 0; i < 3; i++) tick();
    chk("rstmid_busy", 32'(a_ctl), 32'(9'b1110_0010_0));
    reset = 1'b1; #1;
    chk("rstmid_ctl", 32'(a_ctl), 32'(9'b0000_0000_0));
    chk("rstmid_flag", 32'(a_to), 32'(1'b0));
    chk("rstmid_cnt", 32'({a_sc, a_fc}), 32'(8'h00));
    tick();
    reset = 1'b0; #1;
    chk("rstmid_restart", 32'(a_ctl), 32'(9'b1110_0010_1));
    clear_in();
    tick();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
